// File: rtl/pipe_scoreboard.sv
// Hazard scoreboard for an in-order pipeline: tracks in-flight writers, picks forwarding sources, stalls ID.
// Optional macro PIPE_SCOREBOARD_FWD_EN enables forwarding; undefined gives a pure interlock.
module pipe_scoreboard #(
    parameter int DEPTH      = 3,
    parameter int LOAD_STAGE = 2,
    parameter int ADDR_W     = 5,
    localparam int SW        = $clog2(DEPTH + 1)
) (
    input  logic              in_clk,
    input  logic              in_rst,
    input  logic              in_id_valid,
    input  logic [ADDR_W-1:0] in_id_rs_addr,
    input  logic [ADDR_W-1:0] in_id_rt_addr,
    input  logic              in_id_rs_used,
    input  logic              in_id_rt_used,
    input  logic [ADDR_W-1:0] in_id_rd_addr,
    input  logic              in_id_rd_wena,
    input  logic              in_id_is_load,
    input  logic              in_flush,
    output logic              out_stall,
    output logic [SW-1:0]     out_rs_fwd_sel,
    output logic [SW-1:0]     out_rt_fwd_sel,
    output logic [31:0]       out_stall_count,
    output logic [31:0]       out_issue_count
);

`ifdef PIPE_SCOREBOARD_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] rd_addr;
        logic              rd_wena;
        logic              is_load;
    } entry_t;

    typedef struct packed {
        logic          hit;
        logic [SW-1:0] k;
        logic          load;
    } match_t;

    // ent[i] is stage i+1
    entry_t ent [DEPTH];

    match_t rs_m;
    match_t rt_m;
    logic   rs_rdy;
    logic   rt_rdy;
    logic   issue;

    // Scanning oldest to youngest lets the youngest writer win.
    function automatic match_t find(input logic [ADDR_W-1:0] a, input logic used);
        match_t m;
        m = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (used && a != '0 && ent[i].valid && ent[i].rd_wena &&
                ent[i].rd_addr == a) begin
                m.hit  = 1'b1;
                m.k    = SW'(i + 1);
                m.load = ent[i].is_load;
            end
        end
        return m;
    endfunction

    always_comb begin
        rs_m   = find(in_id_rs_addr, in_id_rs_used);
        rt_m   = find(in_id_rt_addr, in_id_rt_used);
        rs_rdy = FWD && rs_m.hit &&
                 (int'(rs_m.k) >= (rs_m.load ? LOAD_STAGE : 1));
        rt_rdy = FWD && rt_m.hit &&
                 (int'(rt_m.k) >= (rt_m.load ? LOAD_STAGE : 1));
        out_stall = !in_rst && in_id_valid && !in_flush &&
                    ((rs_m.hit && !rs_rdy) || (rt_m.hit && !rt_rdy));
        out_rs_fwd_sel = '0;
        out_rt_fwd_sel = '0;
        if (!out_stall && !in_rst) begin
            if (rs_rdy) out_rs_fwd_sel = rs_m.k;
            if (rt_rdy) out_rt_fwd_sel = rt_m.k;
        end
        issue = in_id_valid && !out_stall && !in_flush;
    end

    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            for (int i = 0; i < DEPTH; i++) ent[i] <= '0;
        end else begin
            if (issue)
                ent[0] <= '{valid:   1'b1,
                            rd_addr: in_id_rd_addr,
                            rd_wena: in_id_rd_wena,
                            is_load: in_id_is_load};
            else
                ent[0] <= '0;
            for (int i = 1; i < DEPTH; i++) ent[i] <= ent[i-1];
        end
    end

    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            out_stall_count <= '0;
            out_issue_count <= '0;
        end else begin
            if (out_stall && out_stall_count != '1)
                out_stall_count <= out_stall_count + 32'd1;
            if (issue && out_issue_count != '1)
                out_issue_count <= out_issue_count + 32'd1;
        end
    end

endmodule

// File: tb/tb_pipe_scoreboard.sv
// Directed vector bench for pipe_scoreboard (DEPTH=3, LOAD_STAGE=2).
// Expectations for both builds are carried; the one matching the macro is checked.
module tb_pipe_scoreboard;

`ifdef PIPE_SCOREBOARD_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic       in_clk = 1'b0;
    logic       in_rst;
    logic       in_id_valid;
    logic [4:0] in_id_rs_addr;
    logic [4:0] in_id_rt_addr;
    logic       in_id_rs_used;
    logic       in_id_rt_used;
    logic [4:0] in_id_rd_addr;
    logic       in_id_rd_wena;
    logic       in_id_is_load;
    logic       in_flush;
    logic       out_stall;
    logic [1:0] out_rs_fwd_sel;
    logic [1:0] out_rt_fwd_sel;
    logic [31:0] out_stall_count;
    logic [31:0] out_issue_count;

    int total = 0;
    int bad   = 0;

    pipe_scoreboard #(.DEPTH(3), .LOAD_STAGE(2), .ADDR_W(5)) dut (
        .in_clk          (in_clk),
        .in_rst          (in_rst),
        .in_id_valid     (in_id_valid),
        .in_id_rs_addr   (in_id_rs_addr),
        .in_id_rt_addr   (in_id_rt_addr),
        .in_id_rs_used   (in_id_rs_used),
        .in_id_rt_used   (in_id_rt_used),
        .in_id_rd_addr   (in_id_rd_addr),
        .in_id_rd_wena   (in_id_rd_wena),
        .in_id_is_load   (in_id_is_load),
        .in_flush        (in_flush),
        .out_stall       (out_stall),
        .out_rs_fwd_sel  (out_rs_fwd_sel),
        .out_rt_fwd_sel  (out_rt_fwd_sel),
        .out_stall_count (out_stall_count),
        .out_issue_count (out_issue_count)
    );

    always #5 in_clk = ~in_clk;

    typedef struct {
        logic       v;
        logic [4:0] rs;
        logic       rsu;
        logic [4:0] rt;
        logic       rtu;
        logic [4:0] rd;
        logic       we;
        logic       ld;
        logic       fl;
        logic       sf;
        logic [1:0] rsf;
        logic [1:0] rtf;
        logic       sn;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(
        input logic v, input logic [4:0] rs, input logic rsu,
        input logic [4:0] rt, input logic rtu, input logic [4:0] rd,
        input logic we, input logic ld, input logic fl,
        input logic sf, input logic [1:0] rsf, input logic [1:0] rtf,
        input logic sn);
        vec_t r;
        r.v = v; r.rs = rs; r.rsu = rsu; r.rt = rt; r.rtu = rtu;
        r.rd = rd; r.we = we; r.ld = ld; r.fl = fl;
        r.sf = sf; r.rsf = rsf; r.rtf = rtf; r.sn = sn;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t r);
        in_id_valid   = r.v;
        in_id_rs_addr = r.rs;
        in_id_rs_used = r.rsu;
        in_id_rt_addr = r.rt;
        in_id_rt_used = r.rtu;
        in_id_rd_addr = r.rd;
        in_id_rd_wena = r.we;
        in_id_is_load = r.ld;
        in_flush      = r.fl;
    endtask

    initial begin
        int exp_issue;
        int exp_stalls;
        logic       es;
        logic [1:0] ers;
        logic [1:0] ert;

        // add r3, then a reader of r3 held for four cycles
        tbl.push_back(mk(1, 0, 0, 0, 0, 3, 1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 3, 1, 0, 0, 6, 0, 0, 0, 0, 1, 0, 1));
        tbl.push_back(mk(1, 3, 1, 0, 0, 6, 0, 0, 0, 0, 2, 0, 1));
        tbl.push_back(mk(1, 3, 1, 0, 0, 6, 0, 0, 0, 0, 3, 0, 1));
        tbl.push_back(mk(1, 3, 1, 0, 0, 6, 0, 0, 0, 0, 0, 0, 0));
        // lw r4, then a reader of r4
        tbl.push_back(mk(1, 0, 0, 0, 0, 4, 1, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 4, 1, 0, 0, 6, 0, 0, 0, 1, 0, 0, 1));
        tbl.push_back(mk(1, 4, 1, 0, 0, 6, 0, 0, 0, 0, 2, 0, 1));
        tbl.push_back(mk(1, 4, 1, 0, 0, 6, 0, 0, 0, 0, 3, 0, 1));
        tbl.push_back(mk(1, 4, 1, 0, 0, 6, 0, 0, 0, 0, 0, 0, 0));
        // r5, r7, r5 writers; youngest r5 must win on both sources
        tbl.push_back(mk(1, 0, 0, 0, 0, 5, 1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 7, 1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 5, 1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 5, 1, 5, 1, 6, 0, 0, 0, 0, 1, 1, 1));
        tbl.push_back(mk(1, 5, 1, 5, 1, 6, 0, 0, 0, 0, 2, 2, 1));
        tbl.push_back(mk(1, 5, 1, 5, 1, 6, 0, 0, 0, 0, 3, 3, 1));
        tbl.push_back(mk(1, 5, 1, 5, 1, 6, 0, 0, 0, 0, 0, 0, 0));
        // r0 never matches
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 1, 0, 1, 6, 0, 0, 0, 0, 0, 0, 0));
        // idle ID never stalls
        tbl.push_back(mk(1, 0, 0, 0, 0, 8, 1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 8, 1, 0, 0, 6, 0, 0, 0, 0, 1, 0, 0));
        // load hazard with flush; flushed r10 writer must not enter
        tbl.push_back(mk(1, 0, 0, 0, 0, 9, 1, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 9, 1, 0, 0, 10, 1, 0, 1, 0, 0, 0, 0));
        tbl.push_back(mk(1, 9, 1, 10, 1, 6, 0, 0, 0, 0, 2, 0, 1));
        tbl.push_back(mk(1, 9, 1, 10, 1, 6, 0, 0, 0, 0, 3, 0, 1));
        tbl.push_back(mk(1, 9, 1, 10, 1, 6, 0, 0, 0, 0, 0, 0, 0));

        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        in_rst = 1'b1;
        #3;
        chk("reset_stall", 32'(out_stall), 0);
        chk("reset_rs_sel", 32'(out_rs_fwd_sel), 0);
        chk("reset_stall_cnt", out_stall_count, 0);
        chk("reset_issue_cnt", out_issue_count, 0);
        @(posedge in_clk);
        #1 in_rst = 1'b0;

        exp_issue  = 0;
        exp_stalls = 0;
        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i]);
            es  = FWD ? tbl[i].sf  : tbl[i].sn;
            ers = FWD ? tbl[i].rsf : 2'd0;
            ert = FWD ? tbl[i].rtf : 2'd0;
            #2;
            chk($sformatf("row%0d_stall", i), 32'(out_stall), 32'(es));
            chk($sformatf("row%0d_rs_sel", i), 32'(out_rs_fwd_sel), 32'(ers));
            chk($sformatf("row%0d_rt_sel", i), 32'(out_rt_fwd_sel), 32'(ert));
            if (es) exp_stalls++;
            if (tbl[i].v && !tbl[i].fl && !es) exp_issue++;
            @(posedge in_clk);
            #1;
        end
        chk("stall_count", out_stall_count, 32'(exp_stalls));
        chk("issue_count", out_issue_count, 32'(exp_issue));

        // reset asserted in the middle of a load-use stall
        drive(mk(1, 0, 0, 0, 0, 4, 1, 1, 0, 0, 0, 0, 0));
        @(posedge in_clk);
        #1;
        drive(mk(1, 4, 1, 0, 0, 6, 0, 0, 0, 1, 0, 0, 1));
        #1;
        chk("pre_rst_stall", 32'(out_stall), 1);
        in_rst = 1'b1;
        #1;
        chk("rst_stall", 32'(out_stall), 0);
        chk("rst_rs_sel", 32'(out_rs_fwd_sel), 0);
        chk("rst_stall_cnt", out_stall_count, 0);
        chk("rst_issue_cnt", out_issue_count, 0);
        in_rst = 1'b0;
        #1;
        chk("post_rst_stall", 32'(out_stall), 0);
        @(posedge in_clk);
        #1;
        chk("post_rst_issue", out_issue_count, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipe_scoreboard.md
PIPE_SCOREBOARD -- requirements
Module: pipe_scoreboard

Interface
REQ-001 Parameter DEPTH, default 3; number of tracked stages after ID (1 = EX, DEPTH = last write-back stage); legal range 2..8.
REQ-002 Parameter LOAD_STAGE, default 2; first stage whose output carries load data; legal range 1..DEPTH.
REQ-003 Parameter ADDR_W, default 5; register address width.
REQ-004 in_clk  input  1  single clock; all state updates on its rising edge.
REQ-005 in_rst  input  1  asynchronous, active-high reset.
REQ-006 in_id_valid  input  1  ID holds a real instruction this cycle.
REQ-007 in_id_rs_addr / in_id_rt_addr  input  ADDR_W each  source register addresses.
REQ-008 in_id_rs_used / in_id_rt_used  input  1 each  the corresponding source is read.
REQ-009 in_id_rd_addr  input  ADDR_W  destination register address.
REQ-010 in_id_rd_wena  input  1  the instruction writes rd.
REQ-011 in_id_is_load  input  1  the instruction is a load.
REQ-012 in_flush  input  1  discard the current ID instruction (branch taken).
REQ-013 out_stall  output  1  hold PC and IF/ID; insert a bubble into EX.
REQ-014 out_rs_fwd_sel / out_rt_fwd_sel  output  SW = $clog2(DEPTH+1) each  0 = register file, k = result of stage k.
REQ-015 out_stall_count  output  32  cycles with out_stall asserted.
REQ-016 out_issue_count  output  32  instructions accepted into stage 1.

Function
REQ-017 Each stage entry k SHALL hold {valid, rd_addr, rd_wena, is_load}; every rising edge shifts entry k into k+1 and drops entry DEPTH.
REQ-018 Entry 1 SHALL load the ID instruction when in_id_valid=1, out_stall=0 and in_flush=0; otherwise it SHALL load a bubble (valid=0).
REQ-019 For each used source with a nonzero address, the match SHALL be the smallest k with valid, rd_wena and rd_addr equal to the source address; a source of address 0 or not used never matches.
REQ-020 Match k SHALL be ready when k >= (is_load ? LOAD_STAGE : 1); if ready, fwd_sel = k; if there is no match, fwd_sel = 0.
REQ-021 out_stall SHALL be 1 when in_id_valid=1, in_flush=0 and any matched source is not ready; otherwise 0. It SHALL be combinational from the entries and the ID inputs (zero latency).
REQ-022 While out_stall=1, both fwd_sel outputs SHALL be 0.
REQ-023 When in_flush and a hazard occur together, the flush SHALL win: out_stall=0 and a bubble enters stage 1.
REQ-024 The register file SHALL be written at the end of stage DEPTH with no internal bypass, so matches in stage DEPTH forward.
REQ-025 The counters SHALL increment by 1 per qualifying cycle and saturate at 0xFFFFFFFF.

Reset
REQ-026 in_rst=1 SHALL immediately clear every entry's valid and both counters, independent of the clock.
REQ-027 While in reset: out_stall=0, both fwd_sel outputs=0, both counters=0.
REQ-028 Reset asserted mid-stall SHALL release the stall at once; no pre-reset hazard survives.

Configuration
REQ-029 Macro PIPE_SCOREBOARD_FWD_EN defined: forwarding operates per REQ-020.
REQ-030 Macro PIPE_SCOREBOARD_FWD_EN undefined:
- every match counts as not ready, so any match stalls;
- both fwd_sel outputs are tied to 0;
- the result is a pure interlock pipeline.

Verification
REQ-031 Issue add r3, then next cycle issue a reader of r3 (FWD_EN, DEPTH=3) -> out_stall=0, out_rs_fwd_sel=1.
REQ-032 Issue lw r4, then next cycle issue a reader of r4 (LOAD_STAGE=2) -> out_stall=1 for 1 cycle, then fwd_sel=2; out_stall_count=1.
REQ-033 Write r5 at stage 1 and r5 at stage 3; a reader of r5 -> fwd_sel=1 (youngest match wins).
REQ-034 Same sequence as REQ-031 without FWD_EN -> out_stall=1 for 3 cycles, then fwd_sel=0.
REQ-035 Reader of r0 while stage 1 writes r0 -> no stall, fwd_sel=0.
REQ-036 Load hazard with in_flush=1 in the same cycle -> out_stall=0 and a bubble enters; assert in_rst during a stall -> out_stall=0 within the same cycle and both counters=0.
